// File: rtl/machine_pkg.sv
// Shared constants for the machine operand path: arity tags, field widths
// and bit offsets inside the 129-bit Maybe bundle.
package machine_pkg;

  localparam logic [1:0] OP_NONE = 2'b00;
  localparam logic [1:0] OP_ONE  = 2'b01;
  localparam logic [1:0] OP_TWO  = 2'b10;
  localparam logic [1:0] OP_BAD  = 2'b11;

  localparam int VAL_W    = 63;
  localparam int BUNDLE_W = 128;
  localparam int MAYBE_W  = 129;

  localparam int VLD_BIT = 128;
  localparam int TAG_HI  = 127;
  localparam int TAG_LO  = 126;
  localparam int A_HI    = 125;
  localparam int A_LO    = 63;
  localparam int B_HI    = 62;
  localparam int B_LO    = 0;

  function automatic logic is_bad_tag(input logic [1:0] tag);
    return tag == OP_BAD;
  endfunction

endpackage

// File: rtl/machine_sync_fifo.sv
// Circular-buffer FIFO holding accepted operand bundles; head entry is read
// combinationally from storage so there is no fall-through path.
import machine_pkg::*;

module machine_sync_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = BUNDLE_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rd_data,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (level == LVL_W'(DEPTH));
  assign empty   = (level == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rd_data = mem[rd_ptr];

  // DEPTH is a power of two, so the pointers wrap by plain overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wr_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/machine_operand_queue.sv
// Buffers operand bundles from the check stage for the execute stage, filters
// malformed tags and keeps hazard-bubble / issue statistics.
import machine_pkg::*;

module machine_operand_queue #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [MAYBE_W-1:0]     in_data,
  output logic                   in_ready,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [1:0]             out_tag,
  output logic [VAL_W-1:0]       out_a,
  output logic [VAL_W-1:0]       out_b,
  output logic [$clog2(DEPTH):0] level,
  output logic [CNT_W-1:0]       stall_cycles,
  output logic [CNT_W-1:0]       issued,
  output logic                   bad_tag
);

  logic                vld;
  logic [1:0]          tag;
  logic                push;
  logic                pop;
  logic                full;
  logic                empty;
  logic [BUNDLE_W-1:0] head;

  assign vld       = in_data[VLD_BIT];
  assign tag       = in_data[TAG_HI:TAG_LO];
  assign in_ready  = ~full;
  assign out_valid = ~empty;
  assign push      = vld & in_ready & ~is_bad_tag(tag);
  assign pop       = out_valid & out_ready;

  assign out_tag = head[TAG_HI:TAG_LO];
  assign out_a   = head[A_HI:A_LO];
  assign out_b   = head[B_HI:B_LO];

  machine_sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (BUNDLE_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push),
    .wr_data (in_data[BUNDLE_W-1:0]),
    .pop     (pop),
    .rd_data (head),
    .level   (level),
    .full    (full),
    .empty   (empty)
  );

  // Only check-stage bubbles count as stalls; back-pressure drops are silent.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles <= '0;
      issued       <= '0;
      bad_tag      <= 1'b0;
    end else begin
      if (!vld && stall_cycles != '1) stall_cycles <= stall_cycles + 1'b1;
      if (pop) issued <= issued + 1'b1;
      if (vld && is_bad_tag(tag)) bad_tag <= 1'b1;
    end
  end

endmodule

// File: tb/tb_machine_operand_queue.sv
// Scoreboard bench for machine_operand_queue: a cycle model predicts handshake,
// occupancy and counters; stored bundles are compared in order as they pop.
module tb_machine_operand_queue;

  localparam int DEPTH = 4;
  localparam int CNT_W = 8;
  localparam int SAT   = (1 << CNT_W) - 1;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [128:0]           in_data;
  logic                   in_ready;
  logic                   out_valid;
  logic                   out_ready;
  logic [1:0]             out_tag;
  logic [62:0]            out_a;
  logic [62:0]            out_b;
  logic [$clog2(DEPTH):0] level;
  logic [CNT_W-1:0]       stall_cycles;
  logic [CNT_W-1:0]       issued;
  logic                   bad_tag;

  machine_operand_queue #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_data      (in_data),
    .in_ready     (in_ready),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_tag      (out_tag),
    .out_a        (out_a),
    .out_b        (out_b),
    .level        (level),
    .stall_cycles (stall_cycles),
    .issued       (issued),
    .bad_tag      (bad_tag)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  logic [127:0] exp_q[$];
  int           m_level;
  int           m_stall;
  int           m_issued;
  bit           m_bad;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_state();
    check("level", level, m_level);
    check("out_valid", out_valid, m_level != 0);
    check("in_ready", in_ready, m_level != DEPTH);
    check("stall_cycles", stall_cycles, m_stall);
    check("issued", issued, m_issued);
    check("bad_tag", bad_tag, m_bad);
  endtask

  // Called at a negedge: drive, compare head before the edge, update model.
  task automatic step(input bit v, input logic [1:0] t, input logic [62:0] a,
                      input logic [62:0] b, input bit rdy);
    bit           m_push;
    bit           m_pop;
    logic [127:0] head;
    in_data   = {v, t, a, b};
    out_ready = rdy;
    #1;
    check("in_ready_pre", in_ready, m_level != DEPTH);
    check("out_valid_pre", out_valid, m_level != 0);
    if (m_level != 0) begin
      head = exp_q[0];
      check("out_tag", out_tag, head[127:126]);
      check("out_a", out_a, head[125:63]);
      check("out_b", out_b, head[62:0]);
    end
    m_push = v && (m_level != DEPTH) && (t != 2'b11);
    m_pop  = (m_level != 0) && rdy;
    if (m_pop) void'(exp_q.pop_front());
    if (m_push) exp_q.push_back({t, a, b});
    m_level = m_level + int'(m_push) - int'(m_pop);
    if (!v && m_stall < SAT) m_stall++;
    if (m_pop) m_issued = (m_issued + 1) % (1 << CNT_W);
    if (v && t == 2'b11) m_bad = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_state();
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) step(1'b0, 2'b00, 63'd0, 63'd0, rdy);
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    in_data   = '0;
    out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    m_level  = 0;
    m_stall  = 0;
    m_issued = 0;
    m_bad    = 1'b0;
    check_state();
    check("rst_out_tag", out_tag, 2'b00);
    check("rst_out_a", out_a, 63'd0);
    check("rst_out_b", out_b, 63'd0);
  endtask

  logic [62:0] ra;
  logic [62:0] rb;

  initial begin
    do_reset();

    // Single two-operand bundle flows straight through.
    step(1'b1, 2'b10, 63'h5, 63'h7, 1'b1);
    check("t1_tag", out_tag, 2'b10);
    check("t1_a", out_a, 63'h5);
    check("t1_b", out_b, 63'h7);
    step(1'b0, 2'b00, 63'd0, 63'd0, 1'b1);
    check("t1_issued", issued, 8'd1);
    check("t1_level", level, 3'd0);

    // Fill while blocked; the fifth bundle is dropped.
    for (int i = 1; i <= 5; i++) step(1'b1, 2'b01, 63'(i), 63'd0, 1'b0);
    check("t2_full_level", level, 3'd4);
    check("t2_in_ready", in_ready, 1'b0);
    idle(5, 1'b1);
    check("t2_issued", issued, 8'd5);

    // Steady stream at level 2 with pointer wrap.
    step(1'b1, 2'b10, 63'h100, 63'h200, 1'b0);
    step(1'b1, 2'b10, 63'h101, 63'h201, 1'b0);
    for (int i = 0; i < 20; i++) begin
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      step(1'b1, 2'b10, ra, rb, 1'b1);
      check("t3_level2", level, 3'd2);
    end
    idle(3, 1'b1);

    // Bubbles then a malformed tag.
    do_reset();
    idle(10, 1'b0);
    step(1'b1, 2'b11, 63'h33, 63'h44, 1'b0);
    check("t4_stall10", stall_cycles, 8'd10);
    check("t4_bad", bad_tag, 1'b1);
    check("t4_level", level, 3'd0);
    check("t4_issued", issued, 8'd0);
    idle(SAT, 1'b0);
    check("t4_stall_sat", stall_cycles, 8'hFF);

    // Mid-operation reset flushes entries.
    for (int i = 0; i < 3; i++) step(1'b1, 2'b01, 63'(32'hA0 + i), 63'd0, 1'b0);
    check("t5_level3", level, 3'd3);
    do_reset();
    step(1'b1, 2'b00, 63'd0, 63'd0, 1'b0);
    step(1'b0, 2'b00, 63'd0, 63'd0, 1'b1);
    check("t5_first_issue", issued, 8'd1);
    check("t5_level0", level, 3'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
